// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding and default frame geometry,
// common to the receive and transmit sides.
package uart_pkg;

    localparam int DEFAULT_DATA_BITS  = 8;
    localparam int DEFAULT_OVERSAMPLE = 16;

    typedef enum logic [2:0] {
        ST_IDLE,
        ST_START,
        ST_DATA,
        ST_STOP,
        ST_WAIT_HIGH
    } uart_state_e;

endpackage

// File: rtl/rx_frame_if.sv
// Receiver-side signal bundle: tick enable and serial line in, character and
// status pulses out. The master drives the line; the slave is the receiver.
interface rx_frame_if
    import uart_pkg::*;
#(
    parameter int DATA_BITS = DEFAULT_DATA_BITS
) ();

    logic                 bclk;
    logic                 rxd;
    logic [DATA_BITS-1:0] dout;
    logic                 rx_rdy;
    logic                 frame_err;
    logic                 busy;

    modport master (
        output bclk, rxd,
        input  dout, rx_rdy, frame_err, busy
    );

    modport slave (
        input  bclk, rxd,
        output dout, rx_rdy, frame_err, busy
    );

endinterface

// File: rtl/sync_2ff.sv
// Two-flop synchronizer for a single asynchronous input. RESET_VAL sets what
// both flops hold in reset so the output matches the line's idle level.
module sync_2ff #(
    parameter logic RESET_VAL = 1'b1
) (
    input  logic clk,
    input  logic rst,
    input  logic d_i,
    output logic q_o
);

    logic meta_q;
    logic sync_q;

    // NOTE: non-blocking assignments make both flops sample the pre-edge value,
    // so d_i really takes two clocks to reach q_o.
    always_ff @(posedge clk) begin
        if (!rst) begin
            meta_q <= RESET_VAL;
            sync_q <= RESET_VAL;
        end else begin
            meta_q <= d_i;
            sync_q <= meta_q;
        end
    end

    assign q_o = sync_q;

endmodule

// File: rtl/rx_frame.sv
// Oversampling asynchronous serial receiver (start, DATA_BITS data LSB-first,
// one stop bit). All state advances only on bclk ticks.
module rx_frame
    import uart_pkg::*;
#(
    parameter int DATA_BITS  = DEFAULT_DATA_BITS,
    parameter int OVERSAMPLE = DEFAULT_OVERSAMPLE
) (
    input logic       clk,
    input logic       rst,
    rx_frame_if.slave bus
);

    localparam int TICK_W = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS + 1);

    localparam logic [TICK_W-1:0] TICK_MID  = TICK_W'(OVERSAMPLE / 2 - 1);
    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_FULL  = BIT_W'(DATA_BITS);

    uart_state_e          state_q, state_d;
    logic [TICK_W-1:0]    tick_q, tick_d;
    logic [BIT_W-1:0]     bit_q, bit_d;
    logic [BIT_W-1:0]     bit_next;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic [DATA_BITS-1:0] dout_q, dout_d;
    logic                 rx_rdy_q, rx_rdy_d;
    logic                 frame_err_q, frame_err_d;
    logic                 rxs;

    sync_2ff #(
        .RESET_VAL (1'b1)
    ) u_sync_rxd (
        .clk (clk),
        .rst (rst),
        .d_i (bus.rxd),
        .q_o (rxs)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_q     <= ST_IDLE;
            tick_q      <= '0;
            bit_q       <= '0;
            shift_q     <= '0;
            dout_q      <= '0;
            rx_rdy_q    <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            tick_q      <= tick_d;
            bit_q       <= bit_d;
            shift_q     <= shift_d;
            dout_q      <= dout_d;
            rx_rdy_q    <= rx_rdy_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign bit_next = bit_q + 1'b1;

    // NOTE: every signal driven here gets a default first; a path that leaves
    // one unassigned would infer a latch instead of holding the register.
    always_comb begin
        state_d     = state_q;
        tick_d      = tick_q;
        bit_d       = bit_q;
        shift_d     = shift_q;
        dout_d      = dout_q;
        rx_rdy_d    = 1'b0;
        frame_err_d = 1'b0;

        if (bus.bclk) begin
            unique case (state_q)
                ST_IDLE: begin
                    if (!rxs) begin
                        state_d = ST_START;
                        tick_d  = '0;
                    end
                end
                ST_START: begin
                    // Re-check the line at mid start bit to reject glitches.
                    if (tick_q == TICK_MID) begin
                        if (rxs) begin
                            state_d = ST_IDLE;
                        end else begin
                            state_d = ST_DATA;
                            tick_d  = '0;
                            bit_d   = '0;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_DATA: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d  = '0;
                        shift_d = {rxs, shift_q[DATA_BITS-1:1]};
                        bit_d   = bit_next;
                        if (bit_next == BIT_FULL) begin
                            state_d = ST_STOP;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_STOP: begin
                    if (tick_q == TICK_LAST) begin
                        tick_d = '0;
                        if (rxs) begin
                            dout_d   = shift_q;
                            rx_rdy_d = 1'b1;
                            state_d  = ST_IDLE;
                        end else begin
                            frame_err_d = 1'b1;
                            state_d     = ST_WAIT_HIGH;
                        end
                    end else begin
                        tick_d = tick_q + 1'b1;
                    end
                end
                ST_WAIT_HIGH: begin
                    // A held break reports once, then waits for the line to idle.
                    if (rxs) begin
                        state_d = ST_IDLE;
                    end
                end
                default: begin
                    state_d = ST_IDLE;
                end
            endcase
        end
    end

    assign bus.dout      = dout_q;
    assign bus.rx_rdy    = rx_rdy_q;
    assign bus.frame_err = frame_err_q;
    assign bus.busy      = (state_q != ST_IDLE);

endmodule

// File: doc/rx_frame.md
RX_FRAME -- requirements
Module: rx_frame

Interface
REQ-001 Parameter: DATA_BITS, default 8, number of data bits per frame, 5..8.
REQ-002 Parameter: OVERSAMPLE, default 16, bclk ticks per bit period, even, >= 8.
REQ-003 Port: clk  input  1  sole clock; all logic on its rising edge.
REQ-004 Port: rst  input  1  reset, synchronous, active-low.
REQ-005 Port: bclk  input  1  oversample tick enable, clk-synchronous, one clk cycle wide per tick.
REQ-006 Port: rxd  input  1  asynchronous serial line, idle high.
REQ-007 Port: dout  output  DATA_BITS  last correctly framed character, LSB = first received bit.
REQ-008 Port: rx_rdy  output  1  one-clk pulse: dout updated with a new character.
REQ-009 Port: frame_err  output  1  one-clk pulse: stop bit sampled low.
REQ-010 Port: busy  output  1  high whenever state is not IDLE.

Function
REQ-011 rxd SHALL pass through a 2-flop synchronizer; all decisions use the synchronized value (rxs).
REQ-012 State, tick counter and bit counter SHALL advance only in clk cycles where bclk=1; with bclk=0 all state SHALL hold.
REQ-013 States: IDLE, START, DATA, STOP, WAIT_HIGH.
REQ-014 IDLE: on a tick with rxs=0 -> START, tick counter cleared to 0.
REQ-015 START: on the tick where the counter reaches OVERSAMPLE/2-1 (mid start bit): if rxs=1 -> IDLE (glitch rejected, no pulse); else -> DATA with tick and bit counters cleared.
REQ-016 DATA: every OVERSAMPLE ticks (mid-bit), rxs SHALL be shifted in LSB-first; after DATA_BITS samples -> STOP, counter cleared.
REQ-017 STOP: after OVERSAMPLE ticks sample rxs: 1 -> load dout, pulse rx_rdy, -> IDLE; 0 -> pulse frame_err, dout unchanged, -> WAIT_HIGH.
REQ-018 WAIT_HIGH: stay until a tick with rxs=1, then -> IDLE; a held break SHALL produce exactly one frame_err.
REQ-019 rx_rdy/frame_err SHALL assert in the clk cycle immediately after the stop-sample tick, for exactly one cycle; never both in the same cycle.
REQ-020 dout SHALL hold its value until the next valid frame; the shift register is internal and never visible on dout.
REQ-021 Tick counter width SHALL be clog2(OVERSAMPLE); bit counter width clog2(DATA_BITS+1); no wrap other than explicit clears.
REQ-022 A start edge arriving in the same tick as a stop sample SHALL NOT be detected until the next tick in IDLE.

Reset
REQ-023 With rst=0 at a clk edge: state=IDLE, counters=0, shift register=0, dout=0, rx_rdy=0, frame_err=0, busy=0, synchronizer flops=1.
REQ-024 Reset mid-frame SHALL abandon the frame with no pulse; reception resumes on the next start bit after rst=1.

Structure
REQ-025 Package uart_pkg SHALL hold the state enumeration and the default DATA_BITS/OVERSAMPLE constants, shared with the transmit side.
REQ-026 One sub-module, sync_2ff (2-flop synchronizer, reset value parameter), SHALL be instantiated for rxd.
REQ-027 Output pulses SHALL be registered; no combinational path from rxd to any output.

Verification
REQ-028 Frame 0x55, 8N1, bclk every clk -> one rx_rdy, dout=0x55, frame_err never asserted, busy low afterwards.
REQ-029 Back-to-back frames 0xA3, 0x0F, bclk every 4 clk -> two rx_rdy pulses, dout 0xA3 then 0x0F.
REQ-030 rxd low for 4 ticks then high -> START then IDLE, no rx_rdy, no frame_err, dout unchanged.
REQ-031 Frame 0x3C with stop bit low, line held low 40 ticks -> single frame_err, dout keeps previous value, WAIT_HIGH until rxd=1.
REQ-032 rst=0 during data bit 4 of a frame -> all outputs 0 next cycle; following frame 0x81 received correctly.
REQ-033 bclk held 0 for 100 clk mid-frame -> state frozen; reception completes correctly once ticks resume.
